// File: rtl/dice_pkg.sv
// Shared types and register map for the dice register bank and its arbiter.
package dice_pkg;

    // Arbiter transaction phases.
    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        ACK
    } state_t;

    // Requesters sharing the bank.
    typedef enum logic {
        REQ_I2C,
        REQ_ROLL
    } requester_t;

    // Register map.
    localparam int unsigned ADDR_CFG0 = 0;
    localparam int unsigned ADDR_CFG1 = 1;
    localparam int unsigned ADDR_RES  = 2;

endpackage

// File: rtl/dice_regbank.sv
// DEPTH x 8 flop register bank: one write port, one read port, config taps.
module dice_regbank
    import dice_pkg::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned AW         = 3,
    parameter logic [7:0]  CFG0_RESET = 8'h00
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata,
    output logic [7:0]    cfg0,
    output logic [7:0]    cfg1
);

    logic [7:0] mem_q [DEPTH];

    // Register storage; out-of-range writes are silently dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= (i == ADDR_CFG0) ? CFG0_RESET : 8'h00;
            end
        end else if (we && (32'(waddr) < DEPTH)) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read port and live config taps; out-of-range reads return zero.
    always_comb begin
        rdata = 8'h00;
        if (32'(raddr) < DEPTH) begin
            rdata = mem_q[raddr];
        end
        cfg0 = mem_q[ADDR_CFG0];
        cfg1 = mem_q[ADDR_CFG1];
    end

endmodule

// File: rtl/dice_regbank_arbiter.sv
// Round-robin arbiter sharing the dice register bank between the I2C slave
// and the roll engine, with config write protection and a sticky result flag.
module dice_regbank_arbiter
    import dice_pkg::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned AW         = 3,
    parameter int unsigned PROT_TOP   = 1,
    parameter int unsigned RES_ADDR   = ADDR_RES,
    parameter logic [7:0]  CFG0_RESET = 8'h00
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i2c_req,
    input  logic          i2c_we,
    input  logic [AW-1:0] i2c_addr,
    input  logic [7:0]    i2c_wdata,
    output logic          i2c_ack,
    output logic [7:0]    i2c_rdata,
    input  logic          roll_req,
    input  logic [AW-1:0] roll_addr,
    input  logic [7:0]    roll_wdata,
    output logic          roll_ack,
    output logic          roll_err,
    output logic [7:0]    cfg0,
    output logic [7:0]    cfg1,
    output logic          new_result
);

    state_t        state_q;
    requester_t    last_gnt_q;
    requester_t    lat_who_q;
    logic          lat_we_q;
    logic [AW-1:0] lat_addr_q;
    logic [7:0]    lat_wdata_q;
    logic          i2c_ack_q;
    logic          roll_ack_q;
    logic          roll_err_q;
    logic [7:0]    i2c_rdata_q;
    logic          new_result_q;

    requester_t    winner;
    logic          addr_ok;
    logic          roll_blocked;
    logic          is_res_addr;
    logic          bank_we;
    logic [7:0]    bank_rdata;

    // Winner selection and access qualification for the latched transaction.
    always_comb begin
        winner = REQ_ROLL;
        if (i2c_req && roll_req) begin
            winner = (last_gnt_q == REQ_ROLL) ? REQ_I2C : REQ_ROLL;
        end else if (i2c_req) begin
            winner = REQ_I2C;
        end
        addr_ok      = 32'(lat_addr_q) < DEPTH;
        is_res_addr  = lat_addr_q == AW'(RES_ADDR);
        // Roll engine may not touch config registers or nonexistent ones.
        roll_blocked = (lat_who_q == REQ_ROLL) && ((32'(lat_addr_q) <= PROT_TOP) || !addr_ok);
        bank_we      = (state_q == GRANT) && lat_we_q && !roll_blocked;
    end

    dice_regbank #(
        .DEPTH      (DEPTH),
        .AW         (AW),
        .CFG0_RESET (CFG0_RESET)
    ) u_bank (
        .clk   (clk),
        .rst   (rst),
        .we    (bank_we),
        .waddr (lat_addr_q),
        .wdata (lat_wdata_q),
        .raddr (lat_addr_q),
        .rdata (bank_rdata),
        .cfg0  (cfg0),
        .cfg1  (cfg1)
    );

    // Arbiter FSM: latch winner in IDLE, access in GRANT, retire ack in ACK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_gnt_q   <= REQ_ROLL;
            lat_who_q    <= REQ_I2C;
            lat_we_q     <= 1'b0;
            lat_addr_q   <= '0;
            lat_wdata_q  <= 8'h00;
            i2c_ack_q    <= 1'b0;
            roll_ack_q   <= 1'b0;
            roll_err_q   <= 1'b0;
            i2c_rdata_q  <= 8'h00;
            new_result_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (i2c_req || roll_req) begin
                        lat_who_q  <= winner;
                        last_gnt_q <= winner;
                        if (winner == REQ_I2C) begin
                            lat_we_q    <= i2c_we;
                            lat_addr_q  <= i2c_addr;
                            lat_wdata_q <= i2c_wdata;
                        end else begin
                            lat_we_q    <= 1'b1;
                            lat_addr_q  <= roll_addr;
                            lat_wdata_q <= roll_wdata;
                        end
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (lat_who_q == REQ_I2C) begin
                        i2c_ack_q <= 1'b1;
                        if (!lat_we_q) begin
                            i2c_rdata_q <= bank_rdata;
                            if (is_res_addr) begin
                                new_result_q <= 1'b0;
                            end
                        end
                    end else begin
                        roll_ack_q <= 1'b1;
                        roll_err_q <= roll_blocked;
                        if (!roll_blocked && is_res_addr) begin
                            new_result_q <= 1'b1;
                        end
                    end
                    state_q <= ACK;
                end
                ACK: begin
                    i2c_ack_q  <= 1'b0;
                    roll_ack_q <= 1'b0;
                    roll_err_q <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign i2c_ack    = i2c_ack_q;
    assign i2c_rdata  = i2c_rdata_q;
    assign roll_ack   = roll_ack_q;
    assign roll_err   = roll_err_q;
    assign new_result = new_result_q;

endmodule

// File: tb/tb_dice_regbank_arbiter.sv
// Directed self-checking bench for dice_regbank_arbiter.
module tb_dice_regbank_arbiter;

    logic       clk;
    logic       rst;
    logic       i2c_req;
    logic       i2c_we;
    logic [2:0] i2c_addr;
    logic [7:0] i2c_wdata;
    logic       i2c_ack;
    logic [7:0] i2c_rdata;
    logic       roll_req;
    logic [2:0] roll_addr;
    logic [7:0] roll_wdata;
    logic       roll_ack;
    logic       roll_err;
    logic [7:0] cfg0;
    logic [7:0] cfg1;
    logic       new_result;

    int total;
    int bad;

    dice_regbank_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .i2c_req    (i2c_req),
        .i2c_we     (i2c_we),
        .i2c_addr   (i2c_addr),
        .i2c_wdata  (i2c_wdata),
        .i2c_ack    (i2c_ack),
        .i2c_rdata  (i2c_rdata),
        .roll_req   (roll_req),
        .roll_addr  (roll_addr),
        .roll_wdata (roll_wdata),
        .roll_ack   (roll_ack),
        .roll_err   (roll_err),
        .cfg0       (cfg0),
        .cfg1       (cfg1),
        .new_result (new_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one I2C transaction; report ack latency (posedges), ack width, rdata.
    task automatic i2c_txn(input logic we, input logic [2:0] addr, input logic [7:0] wd,
                           output int lat, output int width, output logic [7:0] rd);
        @(negedge clk);
        i2c_req = 1'b1; i2c_we = we; i2c_addr = addr; i2c_wdata = wd;
        lat = 0; width = 0; rd = 8'hxx;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (i2c_ack) break;
        end
        rd = i2c_rdata;
        i2c_req = 1'b0;
        if (i2c_ack) begin
            width = 1;
            @(posedge clk); #1;
            if (i2c_ack) width = 2;
        end
    endtask

    // Drive one roll write; report ack latency, ack width and roll_err at ack.
    task automatic roll_txn(input logic [2:0] addr, input logic [7:0] wd,
                            output int lat, output int width, output logic err);
        @(negedge clk);
        roll_req = 1'b1; roll_addr = addr; roll_wdata = wd;
        lat = 0; width = 0; err = 1'bx;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (roll_ack) break;
        end
        err = roll_err;
        roll_req = 1'b0;
        if (roll_ack) begin
            width = 1;
            @(posedge clk); #1;
            if (roll_ack) width = 2;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i2c_req = 0; i2c_we = 0; i2c_addr = 0; i2c_wdata = 0;
        roll_req = 0; roll_addr = 0; roll_wdata = 0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({i2c_ack, roll_ack, roll_err, new_result} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags got=%b want=0000", {i2c_ack, roll_ack, roll_err, new_result});
        end
        total++;
        if ({i2c_rdata, cfg0, cfg1} !== 24'h000000) begin
            bad++; $display("FAIL reset_data got=%h want=000000", {i2c_rdata, cfg0, cfg1});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_read_after_reset();
        int lat, width;
        logic [7:0] rd;
        for (int a = 0; a < 8; a++) begin
            i2c_txn(1'b0, 3'(a), 8'h00, lat, width, rd);
            total++;
            if (rd !== 8'h00 || lat !== 2 || width !== 1) begin
                bad++; $display("FAIL reset_read a=%0d got rd=%h lat=%0d w=%0d want rd=00 lat=2 w=1",
                                a, rd, lat, width);
            end
        end
    endtask

    task automatic test_write_readback();
        logic [7:0] pat [8];
        int lat, width;
        logic [7:0] rd;
        pat[0] = 8'hAA; pat[1] = 8'h55; pat[2] = 8'h69; pat[3] = 8'h96;
        pat[4] = 8'h33; pat[5] = 8'hFF; pat[6] = 8'h00; pat[7] = 8'h00;
        for (int a = 0; a < 6; a++) begin
            i2c_txn(1'b1, 3'(a), pat[a], lat, width, rd);
            total++;
            if (lat !== 2 || width !== 1) begin
                bad++; $display("FAIL write_ack a=%0d got lat=%0d w=%0d want lat=2 w=1", a, lat, width);
            end
            if (a == 0) begin
                total++;
                if (cfg0 !== 8'hAA) begin
                    bad++; $display("FAIL cfg0_tap got=%h want=aa", cfg0);
                end
            end
            if (a == 1) begin
                total++;
                if (cfg1 !== 8'h55) begin
                    bad++; $display("FAIL cfg1_tap got=%h want=55", cfg1);
                end
            end
        end
        for (int a = 0; a < 8; a++) begin
            i2c_txn(1'b0, 3'(a), 8'h00, lat, width, rd);
            total++;
            if (rd !== pat[a]) begin
                bad++; $display("FAIL readback a=%0d got=%h want=%h", a, rd, pat[a]);
            end
        end
    endtask

    task automatic test_tie_alternation();
        int n_acks, cyc;
        logic prev_any, i2c_rearm, roll_rearm;
        logic want_roll;
        apply_reset();
        @(negedge clk);
        i2c_we = 1'b0; i2c_addr = 3'd0;
        roll_addr = 3'd5; roll_wdata = 8'h3C;
        i2c_req = 1'b1; roll_req = 1'b1;
        n_acks = 0; cyc = 0; prev_any = 1'b0; i2c_rearm = 0; roll_rearm = 0;
        want_roll = 1'b0;
        while (n_acks < 6 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (i2c_rearm) begin i2c_req = 1'b1; i2c_rearm = 1'b0; end
            if (roll_rearm) begin roll_req = 1'b1; roll_rearm = 1'b0; end
            if (i2c_ack || roll_ack) begin
                total++;
                if (i2c_ack && roll_ack) begin
                    bad++; $display("FAIL tie_both_acks n=%0d got=11 want=one", n_acks);
                end else if (roll_ack !== want_roll) begin
                    bad++; $display("FAIL tie_order n=%0d got roll=%b want roll=%b",
                                    n_acks, roll_ack, want_roll);
                end
                total++;
                if (prev_any) begin
                    bad++; $display("FAIL tie_consecutive n=%0d got=back-to-back want=gap", n_acks);
                end
                if (i2c_ack) begin i2c_req = 1'b0; i2c_rearm = 1'b1; end
                if (roll_ack) begin roll_req = 1'b0; roll_rearm = 1'b1; end
                want_roll = ~want_roll;
                n_acks++;
            end
            prev_any = i2c_ack | roll_ack;
        end
        total++;
        if (n_acks != 6) begin
            bad++; $display("FAIL tie_timeout got=%0d acks want=6", n_acks);
        end
        i2c_req = 1'b0; roll_req = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_protect_and_flag();
        int lat, width;
        logic err;
        logic [7:0] rd;
        i2c_txn(1'b1, 3'd1, 8'h55, lat, width, rd);
        roll_txn(3'd1, 8'h12, lat, width, err);
        total++;
        if (err !== 1'b1 || cfg1 !== 8'h55 || lat !== 2 || width !== 1) begin
            bad++; $display("FAIL roll_prot1 got err=%b cfg1=%h lat=%0d w=%0d want err=1 cfg1=55 lat=2 w=1",
                            err, cfg1, lat, width);
        end
        roll_txn(3'd0, 8'hE1, lat, width, err);
        total++;
        if (err !== 1'b1 || cfg0 !== 8'h00 || new_result !== 1'b0) begin
            bad++; $display("FAIL roll_prot0 got err=%b cfg0=%h nr=%b want err=1 cfg0=00 nr=0",
                            err, cfg0, new_result);
        end
        roll_txn(3'd2, 8'h07, lat, width, err);
        total++;
        if (err !== 1'b0 || new_result !== 1'b1) begin
            bad++; $display("FAIL roll_result got err=%b nr=%b want err=0 nr=1", err, new_result);
        end
        i2c_txn(1'b1, 3'd2, 8'h07, lat, width, rd);
        total++;
        if (new_result !== 1'b1) begin
            bad++; $display("FAIL nr_i2c_write got=%b want=1", new_result);
        end
        i2c_txn(1'b0, 3'd2, 8'h00, lat, width, rd);
        total++;
        if (rd !== 8'h07 || new_result !== 1'b0) begin
            bad++; $display("FAIL result_read got rd=%h nr=%b want rd=07 nr=0", rd, new_result);
        end
        // Roll write leaves the held read data alone and re-arms the flag.
        roll_txn(3'd2, 8'h09, lat, width, err);
        total++;
        if (i2c_rdata !== 8'h07 || new_result !== 1'b1) begin
            bad++; $display("FAIL rdata_hold got rd=%h nr=%b want rd=07 nr=1", i2c_rdata, new_result);
        end
    endtask

    task automatic test_reset_mid_txn();
        int lat, width, acks;
        logic [7:0] rd;
        @(negedge clk);
        i2c_req = 1'b1; i2c_we = 1'b1; i2c_addr = 3'd3; i2c_wdata = 8'h5A;
        @(posedge clk); #1;
        rst = 1'b1;
        i2c_req = 1'b0;
        #1;
        total++;
        if ({i2c_ack, roll_ack, roll_err, new_result} !== 4'b0000 ||
            {i2c_rdata, cfg0, cfg1} !== 24'h000000) begin
            bad++; $display("FAIL mid_reset_outs got=%b %h want=0000 000000",
                            {i2c_ack, roll_ack, roll_err, new_result}, {i2c_rdata, cfg0, cfg1});
        end
        acks = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (i2c_ack) acks++;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (i2c_ack) acks++;
        end
        total++;
        if (acks != 0) begin
            bad++; $display("FAIL mid_reset_noack got=%0d want=0", acks);
        end
        i2c_txn(1'b0, 3'd3, 8'h00, lat, width, rd);
        total++;
        if (rd !== 8'h00) begin
            bad++; $display("FAIL mid_reset_read got=%h want=00", rd);
        end
    endtask

    task automatic test_early_drop_latch();
        int lat, width, acks, lat_seen;
        logic [7:0] rd;
        i2c_txn(1'b1, 3'd4, 8'hC3, lat, width, rd);
        i2c_txn(1'b1, 3'd6, 8'h3C, lat, width, rd);
        @(negedge clk);
        i2c_req = 1'b1; i2c_we = 1'b0; i2c_addr = 3'd4;
        @(posedge clk); #1;
        // Sampled; drop the request and retarget the address before GRANT.
        i2c_req = 1'b0; i2c_addr = 3'd6;
        acks = 0; lat_seen = 0; rd = 8'hxx;
        for (int c = 2; c < 8; c++) begin
            @(posedge clk); #1;
            if (i2c_ack) begin
                acks++;
                if (lat_seen == 0) begin lat_seen = c; rd = i2c_rdata; end
            end
        end
        total++;
        if (acks != 1 || lat_seen != 2) begin
            bad++; $display("FAIL early_drop got acks=%0d lat=%0d want acks=1 lat=2", acks, lat_seen);
        end
        total++;
        if (rd !== 8'hC3) begin
            bad++; $display("FAIL latched_addr got=%h want=c3", rd);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_read_after_reset();
        test_write_readback();
        test_tie_alternation();
        test_protect_and_flag();
        test_reset_mid_txn();
        test_early_drop_latch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
